marie_fetch_exec: RTL



---
 rtl/marie_pkg.sv | 27 ++
 rtl/marie_alu.sv | 33 +++
 rtl/marie_fetch_exec.sv | 136 +++++++++++++
 3 files changed

// File: rtl/marie_pkg.sv
// rtl/marie_pkg.sv - shared opcodes, skip conditions and control states for the MARIE fetch/execute stage
package marie_pkg;

    localparam logic [3:0] OP_LOAD     = 4'h1;
    localparam logic [3:0] OP_STORE    = 4'h2;
    localparam logic [3:0] OP_ADD      = 4'h3;
    localparam logic [3:0] OP_SUBT     = 4'h4;
    localparam logic [3:0] OP_HALT     = 4'h7;
    localparam logic [3:0] OP_SKIPCOND = 4'h8;
    localparam logic [3:0] OP_JUMP     = 4'h9;

    localparam logic [1:0] SK_NEG   = 2'b00;
    localparam logic [1:0] SK_ZERO  = 2'b01;
    localparam logic [1:0] SK_POS   = 2'b10;
    localparam logic [1:0] SK_NEVER = 2'b11;

    typedef enum logic [2:0] {
        FETCH,
        FWAIT,
        DECODE,
        OPER,
        OWAIT,
        STORE,
        HALT
    } state_t;

endpackage

// File: rtl/marie_alu.sv
// rtl/marie_alu.sv - combinational accumulator update and Skipcond decision
module marie_alu
    import marie_pkg::*;
(
    input  logic [15:0] ac,
    input  logic [15:0] rdata,
    input  logic [3:0]  opcode,
    input  logic [1:0]  cond,
    output logic [15:0] ac_next,
    output logic        skip
);

    always_comb begin
        ac_next = ac;
        case (opcode)
            OP_LOAD: ac_next = rdata;
            OP_ADD:  ac_next = ac + rdata;
            OP_SUBT: ac_next = ac - rdata;
            default: ac_next = ac;
        endcase
    end

    always_comb begin
        skip = 1'b0;
        case (cond)
            SK_NEG:  skip = ac[15];
            SK_ZERO: skip = (ac == 16'h0000);
            SK_POS:  skip = !ac[15] && (ac != 16'h0000);
            default: skip = 1'b0;
        endcase
    end

endmodule

// File: rtl/marie_fetch_exec.sv
// rtl/marie_fetch_exec.sv - MARIE fetch/decode/execute control with store handshake
module marie_fetch_exec
    import marie_pkg::*;
#(
    parameter logic [11:0] RESET_PC = 12'h000,
    parameter int          RD_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_rd_en,
    output logic [11:0] mem_addr,
    input  logic [15:0] mem_rdata,
    output logic        st_valid,
    input  logic        st_ready,
    output logic [11:0] X,
    output logic [15:0] AC,
    output logic [11:0] pc,
    output logic [15:0] ir,
    output logic        halted
);

    localparam logic [2:0] CNT_LAST = 3'(RD_LAT - 1);

    state_t      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [15:0] ac_q, ac_d;
    logic [15:0] ir_q, ir_d;
    logic [11:0] x_q, x_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        rd_req;
    logic [15:0] alu_ac;
    logic        alu_skip;

    marie_alu u_alu (
        .ac      (ac_q),
        .rdata   (mem_rdata),
        .opcode  (ir_q[15:12]),
        .cond    (ir_q[11:10]),
        .ac_next (alu_ac),
        .skip    (alu_skip)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ac_q    <= 16'h0000;
            ir_q    <= 16'h0000;
            x_q     <= 12'h000;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ac_q    <= ac_d;
            ir_q    <= ir_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ac_d     = ac_q;
        ir_d     = ir_q;
        x_d      = x_q;
        cnt_d    = cnt_q;
        rd_req   = 1'b0;
        mem_addr = pc_q;
        st_valid = 1'b0;
        halted   = 1'b0;
        case (state_q)
            FETCH: begin
                rd_req  = 1'b1;
                cnt_d   = 3'd0;
                state_d = FWAIT;
            end
            FWAIT: begin
                if (cnt_q == CNT_LAST) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 12'd1;
                    state_d = DECODE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DECODE: begin
                x_d = ir_q[11:0];
                case (ir_q[15:12])
                    OP_LOAD, OP_ADD, OP_SUBT: state_d = OPER;
                    OP_STORE: state_d = STORE;
                    OP_JUMP: begin
                        pc_d    = ir_q[11:0];
                        state_d = FETCH;
                    end
                    OP_SKIPCOND: begin
                        if (alu_skip) pc_d = pc_q + 12'd1;
                        state_d = FETCH;
                    end
                    OP_HALT: state_d = HALT;
                    default: state_d = FETCH;
                endcase
            end
            OPER: begin
                rd_req   = 1'b1;
                mem_addr = x_q;
                cnt_d    = 3'd0;
                state_d  = OWAIT;
            end
            OWAIT: begin
                mem_addr = x_q;
                if (cnt_q == CNT_LAST) begin
                    ac_d    = alu_ac;
                    state_d = FETCH;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            STORE: begin
                st_valid = 1'b1;
                if (st_ready) state_d = FETCH;
            end
            HALT: halted = 1'b1;
            default: state_d = FETCH;
        endcase
    end

    // FETCH is the reset state, so the strobe must be masked while reset is held
    assign mem_rd_en = rd_req && rst;

    assign X  = x_q;
    assign AC = ac_q;
    assign pc = pc_q;
    assign ir = ir_q;

endmodule
